// File: rtl/leiwand_rv32_wb_interconnect_pkg.sv
// leiwand_rv32_wb_interconnect_pkg: FSM state encoding and error-response data for the Wishbone interconnect.
package leiwand_rv32_wb_interconnect_pkg;
    typedef enum logic [1:0] {
        WB_IC_IDLE = 2'd0,
        WB_IC_WAIT = 2'd1,
        WB_IC_ERR  = 2'd2
    } wb_ic_state_e;
    localparam logic [31:0] WB_ERR_DATA = 32'hDEADBEEF;
endpackage

// File: rtl/leiwand_rv32_wb_addr_decode.sv
// leiwand_rv32_wb_addr_decode: priority address-range decode, one-hot (or zero) hit, lowest slave wins.
module leiwand_rv32_wb_addr_decode #(
    parameter int DATA_W = 32,
    parameter int NUM_SLAVES = 2,
    parameter logic [NUM_SLAVES*DATA_W-1:0] SLAVE_BASE = {32'h20400000, 32'h10000000},
    parameter logic [NUM_SLAVES*DATA_W-1:0] SLAVE_SIZE = {32'h4000, 32'h4000}
) (
    input  logic [DATA_W-1:0]     i_addr,
    output logic [NUM_SLAVES-1:0] o_hit
);
    logic [NUM_SLAVES-1:0] w_raw;
    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_rng
        // one extra bit so a region ending at the top of the address space cannot wrap
        logic [DATA_W:0] w_lo, w_hi, w_a;
        assign w_a   = {1'b0, i_addr};
        assign w_lo  = {1'b0, SLAVE_BASE[g*DATA_W +: DATA_W]};
        assign w_hi  = w_lo + {1'b0, SLAVE_SIZE[g*DATA_W +: DATA_W]};
        assign w_raw[g] = (w_a >= w_lo) && (w_a < w_hi);
    end
    assign o_hit = w_raw & (-w_raw);
endmodule

// File: rtl/leiwand_rv32_wb_interconnect.sv
// leiwand_rv32_wb_interconnect: pipelined Wishbone 1-master/N-slave interconnect with error acks for unmapped addresses.
// Optional watchdog on a stuck slave: define LEIWAND_WB_TIMEOUT_EN.
module leiwand_rv32_wb_interconnect
    import leiwand_rv32_wb_interconnect_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_SLAVES = 2,
    parameter logic [NUM_SLAVES*DATA_W-1:0] SLAVE_BASE = {32'h20400000, 32'h10000000},
    parameter logic [NUM_SLAVES*DATA_W-1:0] SLAVE_SIZE = {32'h4000, 32'h4000},
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         m_wb_cyc,
    input  logic                         m_wb_stb,
    input  logic                         m_wb_we,
    input  logic [DATA_W-1:0]            m_wb_addr,
    input  logic [DATA_W-1:0]            m_wb_data_out,
    output logic [DATA_W-1:0]            m_wb_data_in,
    output logic                         m_wb_ack,
    output logic                         m_wb_stall,
    output logic                         m_wb_err,
    output logic [DATA_W-1:0]            s_wb_addr,
    output logic [DATA_W-1:0]            s_wb_data_out,
    output logic                         s_wb_we,
    output logic [NUM_SLAVES-1:0]        s_wb_cyc,
    output logic [NUM_SLAVES-1:0]        s_wb_stb,
    input  logic [NUM_SLAVES-1:0]        s_wb_ack,
    input  logic [NUM_SLAVES-1:0]        s_wb_stall,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_wb_data_in
);
    wb_ic_state_e          r_state, w_next;
    logic [NUM_SLAVES-1:0] r_sel, w_hit;
    logic [DATA_W-1:0]     w_rdata;
    logic                  w_req, w_hit_stall, w_accept, w_sel_ack, w_tmo;

    leiwand_rv32_wb_addr_decode #(
        .DATA_W(DATA_W), .NUM_SLAVES(NUM_SLAVES), .SLAVE_BASE(SLAVE_BASE), .SLAVE_SIZE(SLAVE_SIZE)
    ) u_dec (
        .i_addr(m_wb_addr),
        .o_hit (w_hit)
    );

    assign s_wb_addr     = m_wb_addr;
    assign s_wb_data_out = m_wb_data_out;
    assign s_wb_we       = m_wb_we;
    assign s_wb_cyc      = {NUM_SLAVES{m_wb_cyc}} & (r_state == WB_IC_IDLE ? w_hit : r_sel);
    assign w_req         = m_wb_cyc & m_wb_stb;
    assign w_hit_stall   = |(w_hit & s_wb_stall);
    assign w_accept      = (r_state == WB_IC_IDLE) & w_req & ~w_hit_stall;
    assign w_sel_ack     = |(s_wb_ack & r_sel);

    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < NUM_SLAVES; k++)
            if (r_sel[k]) w_rdata = s_wb_data_in[k*DATA_W +: DATA_W];
    end

`ifdef LEIWAND_WB_TIMEOUT_EN
    localparam int CLOG = $clog2(TIMEOUT_CYC + 1);
    localparam int CNT_W = CLOG < 8 ? 8 : (CLOG > 16 ? 16 : CLOG);
    logic [CNT_W-1:0] r_cnt;
    assign w_tmo = r_cnt == CNT_W'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk) begin
        if (reset || w_accept) r_cnt <= '0;
        else if (r_state == WB_IC_WAIT) r_cnt <= r_cnt + CNT_W'(1);
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = |TIMEOUT_CYC;
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= WB_IC_IDLE;
            r_sel   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) r_sel <= w_hit;
        end
    end

    always_comb begin
        w_next       = r_state;
        s_wb_stb     = '0;
        m_wb_stall   = 1'b1;
        m_wb_ack     = 1'b0;
        m_wb_err     = 1'b0;
        m_wb_data_in = '0;
        case (r_state)
            WB_IC_IDLE: begin
                s_wb_stb   = w_req ? w_hit : '0;
                m_wb_stall = w_hit_stall;
                if (w_accept) w_next = |w_hit ? WB_IC_WAIT : WB_IC_ERR;
            end
            WB_IC_WAIT: begin
                if (!m_wb_cyc) w_next = WB_IC_IDLE;
                else if (w_sel_ack) begin
                    m_wb_ack     = 1'b1;
                    m_wb_data_in = w_rdata;
                    w_next       = WB_IC_IDLE;
                end else if (w_tmo) begin
                    m_wb_ack     = 1'b1;
                    m_wb_err     = 1'b1;
                    m_wb_data_in = DATA_W'(WB_ERR_DATA);
                    w_next       = WB_IC_IDLE;
                end
            end
            WB_IC_ERR: begin
                w_next = WB_IC_IDLE;
                if (m_wb_cyc) begin
                    m_wb_ack     = 1'b1;
                    m_wb_err     = 1'b1;
                    m_wb_data_in = DATA_W'(WB_ERR_DATA);
                end
            end
            default: w_next = WB_IC_IDLE;
        endcase
    end
endmodule

// File: tb/tb_leiwand_rv32_wb_interconnect.sv
// tb_leiwand_rv32_wb_interconnect: decode table, directed multi-cycle sequences and randomized transactions vs. a region-table model.
module tb_leiwand_rv32_wb_interconnect;
    logic        clk = 1'b0;
    logic        reset;
    logic        m_wb_cyc, m_wb_stb, m_wb_we, m_wb_ack, m_wb_stall, m_wb_err;
    logic [31:0] m_wb_addr, m_wb_data_out, m_wb_data_in, s_wb_addr, s_wb_data_out;
    logic        s_wb_we;
    logic [1:0]  s_wb_cyc, s_wb_stb, s_wb_ack, s_wb_stall;
    logic [63:0] s_wb_data_in;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    leiwand_rv32_wb_interconnect #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset),
        .m_wb_cyc(m_wb_cyc), .m_wb_stb(m_wb_stb), .m_wb_we(m_wb_we),
        .m_wb_addr(m_wb_addr), .m_wb_data_out(m_wb_data_out), .m_wb_data_in(m_wb_data_in),
        .m_wb_ack(m_wb_ack), .m_wb_stall(m_wb_stall), .m_wb_err(m_wb_err),
        .s_wb_addr(s_wb_addr), .s_wb_data_out(s_wb_data_out), .s_wb_we(s_wb_we),
        .s_wb_cyc(s_wb_cyc), .s_wb_stb(s_wb_stb), .s_wb_ack(s_wb_ack),
        .s_wb_stall(s_wb_stall), .s_wb_data_in(s_wb_data_in)
    );

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  sst;
        logic [1:0]  stb;
        logic        stall;
    } vec_t;
    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic we);
        m_wb_cyc = 1'b1; m_wb_stb = 1'b1; m_wb_addr = a; m_wb_we = we;
    endtask

    function automatic int ref_slave(input logic [31:0] a);
        longint x = longint'(a);
        if (x >= 64'h1000_0000 && x < 64'h1000_0000 + 64'h4000) return 0;
        if (x >= 64'h2040_0000 && x < 64'h2040_0000 + 64'h4000) return 1;
        return -1;
    endfunction

    function automatic logic [1:0] onehot(input int s);
        return s < 0 ? 2'b00 : (s == 0 ? 2'b01 : 2'b10);
    endfunction

    logic [31:0] edges[6];
    int seen, first;

    initial begin
        vt[0]  = '{32'h1000_0000, 2'b00, 2'b01, 1'b0};
        vt[1]  = '{32'h1000_3FFC, 2'b00, 2'b01, 1'b0};
        vt[2]  = '{32'h1000_4000, 2'b11, 2'b00, 1'b0};
        vt[3]  = '{32'h0FFF_FFFC, 2'b00, 2'b00, 1'b0};
        vt[4]  = '{32'h2040_0000, 2'b00, 2'b10, 1'b0};
        vt[5]  = '{32'h2040_3FFF, 2'b00, 2'b10, 1'b0};
        vt[6]  = '{32'h2040_4000, 2'b00, 2'b00, 1'b0};
        vt[7]  = '{32'h1000_0010, 2'b01, 2'b01, 1'b1};
        vt[8]  = '{32'h1000_0010, 2'b10, 2'b01, 1'b0};
        vt[9]  = '{32'h2040_0004, 2'b10, 2'b10, 1'b1};
        vt[10] = '{32'hFFFF_FFFF, 2'b11, 2'b00, 1'b0};
        vt[11] = '{32'h203F_FFFF, 2'b00, 2'b00, 1'b0};
        edges = '{32'h1000_3FFF, 32'h1000_4000, 32'h0FFF_FFFF, 32'h2040_3FFF, 32'h2040_4000, 32'h203F_FFFF};

        reset = 1'b1; m_wb_cyc = 0; m_wb_stb = 0; m_wb_we = 0; m_wb_addr = 0; m_wb_data_out = 0;
        s_wb_ack = 0; s_wb_stall = 0; s_wb_data_in = 0;
        step(); step(); #2;
        chk("rst_ack", 32'(m_wb_ack), 0);
        chk("rst_err", 32'(m_wb_err), 0);
        chk("rst_data", m_wb_data_in, 0);
        chk("rst_stall", 32'(m_wb_stall), 0);
        chk("rst_stb", 32'(s_wb_stb), 0);
        reset = 1'b0;

        foreach (vt[i]) begin
            step();
            req(vt[i].addr, 1'b0); s_wb_stall = vt[i].sst;
            #2;
            chk($sformatf("dec_stb[%0d]", i), 32'(s_wb_stb), 32'(vt[i].stb));
            chk($sformatf("dec_cyc[%0d]", i), 32'(s_wb_cyc), 32'(vt[i].stb));
            chk($sformatf("dec_stall[%0d]", i), 32'(m_wb_stall), 32'(vt[i].stall));
            m_wb_cyc = 0; m_wb_stb = 0; s_wb_stall = 0;
        end

        // read slave0, ack one cycle after accept
        step(); req(32'h1000_0010, 1'b0); #2;
        chk("t1_stb", 32'(s_wb_stb), 32'h1);
        step(); m_wb_stb = 0; s_wb_ack = 2'b01; s_wb_data_in = {32'h0, 32'h1122_3344}; #2;
        chk("t1_stb_off", 32'(s_wb_stb), 0);
        chk("t1_ack", 32'(m_wb_ack), 1);
        chk("t1_data", m_wb_data_in, 32'h1122_3344);
        chk("t1_err", 32'(m_wb_err), 0);
        step(); m_wb_cyc = 0; s_wb_ack = 0; #2;
        chk("t1_ack_once", 32'(m_wb_ack), 0);

        // write slave1 held off by two stall cycles
        step(); req(32'h2040_0004, 1'b1); m_wb_data_out = 32'hCAFE_0001; s_wb_stall = 2'b10;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("t2_stall", 32'(m_wb_stall), 1);
            chk("t2_stb_held", 32'(s_wb_stb), 32'h2);
            step();
        end
        s_wb_stall = 0; #2;
        chk("t2_accept", 32'(m_wb_stall), 0);
        chk("t2_we", 32'(s_wb_we), 1);
        chk("t2_wdata", s_wb_data_out, 32'hCAFE_0001);
        step(); m_wb_stb = 0; #2;
        chk("t2_wait_noack", 32'(m_wb_ack), 0);
        chk("t2_wait_stb", 32'(s_wb_stb), 0);
        chk("t2_wait_cyc", 32'(s_wb_cyc), 32'h2);
        step(); s_wb_ack = 2'b10; #2;
        chk("t2_ack", 32'(m_wb_ack), 1);
        chk("t2_err", 32'(m_wb_err), 0);
        step(); m_wb_cyc = 0; s_wb_ack = 0;

        // unmapped read
        step(); req(32'h3000_0000, 1'b0); #2;
        chk("t3_stb", 32'(s_wb_stb), 0);
        chk("t3_stall", 32'(m_wb_stall), 0);
        step(); m_wb_stb = 0; #2;
        chk("t3_ack", 32'(m_wb_ack), 1);
        chk("t3_err", 32'(m_wb_err), 1);
        chk("t3_data", m_wb_data_in, 32'hDEAD_BEEF);
        step(); m_wb_cyc = 0; #2;
        chk("t3_single", 32'(m_wb_ack), 0);

        // spurious ack from the unselected slave
        step(); req(32'h2040_0000, 1'b0);
        step(); m_wb_stb = 0; s_wb_ack = 2'b01; s_wb_data_in = {32'h5566_7788, 32'hAAAA_AAAA}; #2;
        chk("t4_spurious", 32'(m_wb_ack), 0);
        step(); s_wb_ack = 2'b10; #2;
        chk("t4_ack", 32'(m_wb_ack), 1);
        chk("t4_data", m_wb_data_in, 32'h5566_7788);
        step(); m_wb_cyc = 0; s_wb_ack = 0;

        // master abandons the cycle, slave acks late
        step(); req(32'h1000_0000, 1'b0);
        step(); m_wb_stb = 0; m_wb_cyc = 0; #2;
        chk("t5_abort", 32'(m_wb_ack), 0);
        step(); s_wb_ack = 2'b01; #2;
        chk("t5_late", 32'(m_wb_ack), 0);
        chk("t5_idle", 32'(m_wb_stall), 0);
        step(); s_wb_ack = 0; req(32'h1000_0000, 1'b0);
        step(); m_wb_stb = 0; s_wb_ack = 2'b01; s_wb_data_in = {32'h0, 32'h0BAD_F00D}; #2;
        chk("t5_ack", 32'(m_wb_ack), 1);
        chk("t5_data", m_wb_data_in, 32'h0BAD_F00D);
        step(); m_wb_cyc = 0; s_wb_ack = 0;

        // reset in the middle of a transaction
        step(); req(32'h1000_0000, 1'b0);
        step(); m_wb_stb = 0; reset = 1'b1;
        step(); reset = 1'b0; s_wb_ack = 2'b01; #2;
        chk("rst_mid_ack", 32'(m_wb_ack), 0);
        chk("rst_mid_stall", 32'(m_wb_stall), 0);
        step(); m_wb_cyc = 0; s_wb_ack = 0;

        // slave that never answers
        step(); req(32'h2040_0008, 1'b0);
        step(); m_wb_stb = 0;
        seen = 0; first = 0;
        for (int i = 1; i <= 1000; i++) begin
            #2;
            if (m_wb_ack) begin
                seen++;
                if (first == 0) first = i;
`ifdef LEIWAND_WB_TIMEOUT_EN
                chk("t6_tmo_err", 32'(m_wb_err), 1);
                chk("t6_tmo_data", m_wb_data_in, 32'hDEAD_BEEF);
`endif
            end
            step();
        end
`ifdef LEIWAND_WB_TIMEOUT_EN
        chk("t6_tmo_cycle", 32'(first), 16);
        chk("t6_tmo_count", 32'(seen), 1);
`else
        chk("t6_no_ack", 32'(seen), 0);
`endif
        m_wb_cyc = 0;
        step();

        // randomized transactions against the region model
        for (int it = 0; it < 80; it++) begin
            logic [31:0] a, d0, d1;
            logic [1:0]  e;
            int s, nst, lat;
            case ($urandom_range(0, 3))
                0: a = 32'h1000_0000 + 32'($urandom_range(0, 32'h3FFF));
                1: a = 32'h2040_0000 + 32'($urandom_range(0, 32'h3FFF));
                2: a = $urandom;
                default: a = edges[$urandom_range(0, 5)];
            endcase
            s = ref_slave(a); e = onehot(s);
            nst = s < 0 ? 0 : int'($urandom_range(0, 2));
            lat = $urandom_range(1, 3);
            d0 = $urandom; d1 = $urandom;
            s_wb_data_in = {d1, d0};
            req(a, 1'($urandom)); m_wb_data_out = $urandom; s_wb_ack = 0;
            for (int i = 0; i < nst; i++) begin
                s_wb_stall = e | (2'($urandom) & ~e); #2;
                chk("rnd_stall", 32'(m_wb_stall), 1);
                chk("rnd_stb_stalled", 32'(s_wb_stb), 32'(e));
                step();
            end
            s_wb_stall = 2'($urandom) & ~e; s_wb_ack = 2'($urandom); #2;
            chk("rnd_accept", 32'(m_wb_stall), 0);
            chk("rnd_stb", 32'(s_wb_stb), 32'(e));
            chk("rnd_accept_noack", 32'(m_wb_ack), 0);
            chk("rnd_addr", s_wb_addr, a);
            chk("rnd_wdata", s_wb_data_out, m_wb_data_out);
            step(); m_wb_stb = 1'($urandom); s_wb_stall = 0;
            if (s < 0) begin
                s_wb_ack = 2'($urandom); #2;
                chk("rnd_err_ack", 32'(m_wb_ack), 1);
                chk("rnd_err", 32'(m_wb_err), 1);
                chk("rnd_err_data", m_wb_data_in, 32'hDEAD_BEEF);
            end else begin
                for (int i = 1; i < lat; i++) begin
                    s_wb_ack = 2'($urandom) & ~e; #2;
                    chk("rnd_wait_noack", 32'(m_wb_ack), 0);
                    chk("rnd_wait_stb", 32'(s_wb_stb), 0);
                    step();
                end
                s_wb_ack = e | (2'($urandom) & ~e); #2;
                chk("rnd_ack", 32'(m_wb_ack), 1);
                chk("rnd_ok", 32'(m_wb_err), 0);
                chk("rnd_data", m_wb_data_in, s == 0 ? d0 : d1);
            end
            step(); m_wb_cyc = 0; m_wb_stb = 0; s_wb_ack = 0; #2;
            chk("rnd_idle", 32'(m_wb_ack), 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
